// File: rtl/tile_draw_arbiter.sv
// rtl/tile_draw_arbiter.sv - round-robin arbiter streaming square tiles onto the VGA pixel port (option: TILE_DRAW_CLIP_EN)
module tile_draw_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int TILE_LOG2 = 2,
    parameter int X_W       = 8,
    parameter int Y_W       = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*3-1:0]   req_colour,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int KW = 2 * TILE_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        last;
    logic [KW-1:0]        k;
    logic [X_W-1:0]       base_x;
    logic [Y_W-1:0]       base_y;
    logic [2:0]           base_colour;
    logic [NUM_REQ-1:0]   grant_r;

    logic                 found;
    logic [IW-1:0]        sel;
    logic [IW-1:0]        idx;

    logic [TILE_LOG2-1:0] dx;
    logic [TILE_LOG2-1:0] dy;

    // Round-robin pick: first set request after the most recently served one.
    always_comb begin
        found = 1'b0;
        sel   = last;
        idx   = last;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // Burst sequencer: latch the winner's tile in IDLE, walk all pixels, pulse done.
    // The counter stops on its last value so the pixel outputs hold after a burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            grant_r     <= '0;
            last        <= IW'(NUM_REQ - 1);
            k           <= '0;
            base_x      <= '0;
            base_y      <= '0;
            base_colour <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        base_x      <= req_x[int'(sel)*X_W +: X_W];
                        base_y      <= req_y[int'(sel)*Y_W +: Y_W];
                        base_colour <= req_colour[int'(sel)*3 +: 3];
                        grant_r     <= NUM_REQ'(1) << sel;
                        last        <= sel;
                        k           <= '0;
                        state       <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (k == '1) begin
                        state <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    grant_r <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    grant_r <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_r;
    assign done       = (state == S_DONE) ? grant_r : '0;
    assign busy       = (state != S_IDLE);
    assign vga_colour = base_colour;

    // Row-major scan: low counter bits step x, high bits step y.
    assign dx = k[TILE_LOG2-1:0];
    assign dy = k[KW-1:TILE_LOG2];

`ifdef TILE_DRAW_CLIP_EN
    localparam logic [X_W:0] CLIP_X = (X_W+1)'(160);
    localparam logic [Y_W:0] CLIP_Y = (Y_W+1)'(120);

    logic [X_W:0] px;
    logic [Y_W:0] py;

    // One extra bit so off-screen pixels are detected rather than wrapped.
    assign px       = {1'b0, base_x} + (X_W+1)'(dx);
    assign py       = {1'b0, base_y} + (Y_W+1)'(dy);
    assign vga_x    = px[X_W-1:0];
    assign vga_y    = py[Y_W-1:0];
    assign vga_plot = (state == S_DRAW) && (px < CLIP_X) && (py < CLIP_Y);
`else
    assign vga_x    = base_x + X_W'(dx);
    assign vga_y    = base_y + Y_W'(dy);
    assign vga_plot = (state == S_DRAW);
`endif

endmodule

// File: tb/tb_tile_draw_arbiter.sv
// tb/tb_tile_draw_arbiter.sv - randomized model-checked bench for tile_draw_arbiter
module tb_tile_draw_arbiter;

    localparam int N   = 3;
    localparam int TL  = 2;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int SIDE = 1 << TL;
    localparam int PIX = SIDE * SIDE;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*XW-1:0] req_x;
    logic [N*YW-1:0] req_y;
    logic [N*3-1:0]  req_colour;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            busy;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [2:0]      vga_colour;
    logic            vga_plot;

    always #5 clk = ~clk;

    tile_draw_arbiter #(.NUM_REQ(N), .TILE_LOG2(TL), .X_W(XW), .Y_W(YW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .grant(grant), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ph = -1 idle, 0..PIX-1 pixel index of the burst, PIX = done cycle.
    int ph = -1;
    int owner = 0;
    int last_i = N - 1;
    int bx = 0, by = 0, bc = 0;
    int hx = 0, hy = 0;

    int gq[$];
    int dcount;
    int plots;
    int busy_cycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int fx, fy, ep, eg, ed;
        eg = (ph >= 0) ? (1 << owner) : 0;
        ed = (ph == PIX) ? (1 << owner) : 0;
        ep = 0;
        if (ph >= 0 && ph < PIX) begin
            fx = bx + ph % SIDE;
            fy = by + ph / SIDE;
            hx = fx % (1 << XW);
            hy = fy % (1 << YW);
            ep = 1;
`ifdef TILE_DRAW_CLIP_EN
            if (fx >= 160 || fy >= 120) ep = 0;
`endif
        end
        check("grant", 32'(grant), eg);
        check("done", 32'(done), ed);
        check("busy", 32'(busy), (ph >= 0) ? 1 : 0);
        check("plot", 32'(vga_plot), ep);
        check("vga_x", 32'(vga_x), hx);
        check("vga_y", 32'(vga_y), hy);
        check("vga_colour", 32'(vga_colour), bc);
    endtask

    task automatic step_model();
        int j, found;
        if (reset) begin
            ph = -1; last_i = N - 1;
            bx = 0; by = 0; bc = 0; hx = 0; hy = 0;
        end else if (ph < 0) begin
            found = 0;
            for (int i = 1; i <= N; i++) begin
                j = (last_i + i) % N;
                if (found == 0 && req[j]) begin
                    found = 1;
                    owner = j;
                end
            end
            if (found != 0) begin
                last_i = owner;
                bx = int'(req_x[owner*XW +: XW]);
                by = int'(req_y[owner*YW +: YW]);
                bc = int'(req_colour[owner*3 +: 3]);
                ph = 0;
            end
        end else if (ph < PIX) begin
            ph++;
        end else begin
            ph = -1;
        end
    endtask

    // Inputs set before a tick are what the DUT samples on the next rising edge.
    task automatic tick();
        step_model();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic set_tile(input int i, input int x, input int y, input int c);
        req_x[i*XW +: XW]   = XW'(x);
        req_y[i*YW +: YW]   = YW'(y);
        req_colour[i*3 +: 3] = 3'(c);
    endtask

    // Runs n cycles, logging DUT grant at each burst start and counting DUT done pulses.
    task automatic run_collect(input int n, input bit bounce);
        int hold_off, who;
        hold_off = 0;
        who = 0;
        gq.delete();
        dcount = 0;
        for (int c = 0; c < n; c++) begin
            tick();
            if (ph == 0) gq.push_back(int'(grant));
            if (done != '0) dcount++;
            if (bounce) begin
                if (ph == PIX) begin
                    req[owner] = 1'b0;
                    who = owner;
                    hold_off = 2;
                end else if (hold_off > 0) begin
                    hold_off--;
                    if (hold_off == 0) req[who] = 1'b1;
                end
            end
        end
    endtask

    // Runs until the current burst's done cycle, drops that request, then one idle cycle.
    task automatic finish_burst(input string name, input logic [N-1:0] exp_done);
        int c;
        c = 0;
        while (ph != PIX && c < 40) begin
            tick();
            c++;
        end
        check({name, "_reached_done"}, 32'(ph == PIX), 1);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        req[owner] = 1'b0;
        tick();
    endtask

    function automatic int rand_x();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 255));
            1: return int'($urandom_range(252, 255));
            2: return int'($urandom_range(155, 159));
            default: return int'($urandom_range(0, 159));
        endcase
    endfunction

    function automatic int rand_y();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 127));
            1: return int'($urandom_range(124, 127));
            2: return int'($urandom_range(115, 119));
            default: return int'($urandom_range(0, 119));
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req = '0;
        req_x = '0;
        req_y = '0;
        req_colour = '0;

        // Reset state.
        tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_plot", 32'(vga_plot), 0);
        check("rst_vga_x", 32'(vga_x), 0);
        reset = 1'b0;

        // Single request: 16 row-major pixels from (80,60), done at t+17.
        set_tile(0, 80, 60, 3'b010);
        req = 3'b001;
        for (int c = 0; c < PIX; c++) begin
            tick();
            check("single_x", 32'(vga_x), 80 + c % 4);
            check("single_y", 32'(vga_y), 60 + c / 4);
            check("single_grant", 32'(grant), 1);
            check("single_colour", 32'(vga_colour), 2);
        end
        tick();
        check("single_done", 32'(done), 1);
        check("single_done_plot", 32'(vga_plot), 0);
        req = '0;
        tick();
        check("single_idle", 32'(busy), 0);
        check("single_hold_x", 32'(vga_x), 83);

        // Contention: all three held -> 0,1,2,0 at 18-cycle spacing.
        do_reset();
        for (int i = 0; i < N; i++) set_tile(i, 10 * i, 5 * i, i + 1);
        req = 3'b111;
        run_collect(72, 1'b0);
        check("cont_bursts", gq.size(), 4);
        check("cont_g0", (gq.size() > 0) ? gq[0] : -1, 1);
        check("cont_g1", (gq.size() > 1) ? gq[1] : -1, 2);
        check("cont_g2", (gq.size() > 2) ? gq[2] : -1, 4);
        check("cont_g3", (gq.size() > 3) ? gq[3] : -1, 1);
        check("cont_dones", dcount, 4);

        // Fairness: req 0 and 1 each drop for one idle cycle after done, then re-raise.
        do_reset();
        req = 3'b011;
        run_collect(72, 1'b1);
        check("fair_g0", (gq.size() > 0) ? gq[0] : -1, 1);
        check("fair_g1", (gq.size() > 1) ? gq[1] : -1, 2);
        check("fair_g2", (gq.size() > 2) ? gq[2] : -1, 1);
        check("fair_g3", (gq.size() > 3) ? gq[3] : -1, 2);
        req = '0;
        repeat (20) tick();

        // Mid-burst change: moving req_x[1] and dropping req[1] leaves the burst intact.
        do_reset();
        set_tile(1, 40, 50, 6);
        req = 3'b010;
        repeat (4) tick();
        req_x[XW +: XW] = 8'd10;
        req[1] = 1'b0;
        tick();
        check("mid_x_k4", 32'(vga_x), 40);
        check("mid_y_k4", 32'(vga_y), 51);
        tick();
        check("mid_x_k5", 32'(vga_x), 41);
        run_collect(30, 1'b0);
        check("mid_dones", dcount, 1);
        check("mid_no_regrant", gq.size(), 0);

        // Reset at pixel 7, then requester 2 alone.
        do_reset();
        set_tile(2, 20, 30, 5);
        req = 3'b100;
        repeat (8) tick();
        check("rstmid_pixel7_x", 32'(vga_x), 23);
        reset = 1'b1;
        tick();
        check("rstmid_grant", 32'(grant), 0);
        check("rstmid_plot", 32'(vga_plot), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_done", 32'(done), 0);
        reset = 1'b0;
        tick();
        check("rstmid_regrant", 32'(grant), 4);
        check("rstmid_x", 32'(vga_x), 20);
        finish_burst("rstmid", 3'b100);

        // Edge tile at (158,118).
        do_reset();
        set_tile(0, 158, 118, 7);
        req = 3'b001;
        plots = 0;
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (vga_plot) plots++;
            if (busy) busy_cycles++;
            if (ph == PIX) req = '0;
        end
`ifdef TILE_DRAW_CLIP_EN
        check("edge_plots", plots, 4);
`else
        check("edge_plots", plots, 16);
`endif
        check("edge_busy_cycles", busy_cycles, PIX + 1);
        check("edge_hold_x", 32'(vga_x), 161);
        check("edge_hold_y", 32'(vga_y), 121);

        // Randomized traffic with protocol-following requesters and rare resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if (ph == PIX && owner == i) begin
                    req[i] = ($urandom_range(0, 3) == 0);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[i] = 1'b1;
                        set_tile(i, rand_x(), rand_y(), int'($urandom_range(0, 7)));
                    end
                end else if ($urandom_range(0, 40) == 0) begin
                    req[i] = 1'b0;
                end
                if ($urandom_range(0, 9) == 0) req_x[i*XW +: XW] = XW'(rand_x());
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
